// File: rtl/div_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// div_ctrl
//   Sequences the iterative 32-bit divider for the EX stage. Decodes RISC-V
//   DIV/DIVU/REM/REMU, answers divide-by-zero and signed overflow in one cycle,
//   reuses the last divider result when the operands repeat, and drives the
//   divider's start/stop/annul handshake.
//
// Handshake semantics (EX side and divider side):
//   EX raises req_i (level) with op_i/rs1_i/rs2_i stable. A request is taken
//   in any cycle where the controller is idle and flush_i=0. busy_o stalls EX
//   until the controller is idle again. valid_o is a one-cycle strobe with
//   result_o; EX drops req_i in that same cycle. Towards the divider,
//   div_start_o=1 holds a request with stable operands; div_ready_i=1 marks
//   div_result_i valid. Dropping div_start_o stops the divider, div_annul_o
//   pulses one cycle to abandon an operation. div_start_o stays low for at
//   least DRAIN_CYCLES cycles and until div_ready_i has fallen before the next
//   start.
//
// Ports:
//   ck_i, rs_n_i          clock, asynchronous active-low reset
//   req_i, op_i           EX request and operation (00 DIV,01 DIVU,10 REM,11 REMU)
//   rs1_i, rs2_i          dividend, divisor
//   flush_i               kill pending/in-flight operation
//   busy_o                EX stall, high while not idle
//   valid_o, result_o     result strobe and selected quotient/remainder
//   div_signed_o, div_dividend_o, div_divisor_o, div_start_o, div_annul_o
//                         divider request side
//   div_ready_i, div_result_i  divider completion ([31:0] q, [63:32] r)
//   dbg_state             current FSM state (0 idle, 1 fast, 2 wait, 3 drain)
// -----------------------------------------------------------------------------
module div_ctrl #(
   parameter bit REUSE_EN     = 1'b1,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic        ck_i,
   input  logic        rs_n_i,
   input  logic        req_i,
   input  logic [1:0]  op_i,
   input  logic [31:0] rs1_i,
   input  logic [31:0] rs2_i,
   input  logic        flush_i,
   output logic        busy_o,
   output logic        valid_o,
   output logic [31:0] result_o,
   output logic        div_signed_o,
   output logic [31:0] div_dividend_o,
   output logic [31:0] div_divisor_o,
   output logic        div_start_o,
   output logic        div_annul_o,
   input  logic        div_ready_i,
   input  logic [63:0] div_result_i,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FAST  = 2'd1,
      S_WAIT  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

   state_t state, state_d;

   logic             busy, busy_d;
   logic             valid_q, valid_d;
   logic [31:0]      result_q, result_d;
   logic             signed_q, signed_d;
   logic [31:0]      dividend_q, dividend_d;
   logic [31:0]      divisor_q, divisor_d;
   logic             start_q, start_d;
   logic             annul_q, annul_d;
   logic             rem_q, rem_d;
   logic [CNT_W-1:0] drain_cnt, drain_cnt_d;

   // single-entry reuse cache
   logic             cache_v, cache_v_d;
   logic [31:0]      cache_a, cache_a_d;
   logic [31:0]      cache_b, cache_b_d;
   logic             cache_s, cache_s_d;
   logic [31:0]      cache_q, cache_q_d;
   logic [31:0]      cache_r, cache_r_d;

   // request classification
   logic        op_signed, op_rem;
   logic        is_zero, is_ovf, is_hit, is_fast;
   logic [31:0] fast_q, fast_r;

   assign op_signed = ~op_i[0];
   assign op_rem    = op_i[1];
   assign is_zero   = (rs2_i == 32'h0000_0000);
   assign is_ovf    = op_signed && (rs1_i == 32'h8000_0000) && (rs2_i == 32'hFFFF_FFFF);
   assign is_hit    = REUSE_EN && cache_v && (rs1_i == cache_a) &&
                      (rs2_i == cache_b) && (op_signed == cache_s);
   assign is_fast   = is_zero || is_ovf || is_hit;

   always_comb begin
      fast_q = cache_q;
      fast_r = cache_r;
      if (is_zero) begin
         fast_q = 32'hFFFF_FFFF;
         fast_r = rs1_i;
      end else if (is_ovf) begin
         fast_q = 32'h8000_0000;
         fast_r = 32'h0000_0000;
      end
   end

   always_ff @(posedge ck_i or negedge rs_n_i) begin
      if (!rs_n_i) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         valid_q    <= 1'b0;
         result_q   <= '0;
         signed_q   <= 1'b0;
         dividend_q <= '0;
         divisor_q  <= '0;
         start_q    <= 1'b0;
         annul_q    <= 1'b0;
         rem_q      <= 1'b0;
         drain_cnt  <= '0;
         cache_v    <= 1'b0;
         cache_a    <= '0;
         cache_b    <= '0;
         cache_s    <= 1'b0;
         cache_q    <= '0;
         cache_r    <= '0;
      end else begin
         state      <= state_d;
         busy       <= busy_d;
         valid_q    <= valid_d;
         result_q   <= result_d;
         signed_q   <= signed_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         start_q    <= start_d;
         annul_q    <= annul_d;
         rem_q      <= rem_d;
         drain_cnt  <= drain_cnt_d;
         cache_v    <= cache_v_d;
         cache_a    <= cache_a_d;
         cache_b    <= cache_b_d;
         cache_s    <= cache_s_d;
         cache_q    <= cache_q_d;
         cache_r    <= cache_r_d;
      end
   end

   always_comb begin
      state_d     = state;
      valid_d     = 1'b0;
      result_d    = result_q;
      signed_d    = signed_q;
      dividend_d  = dividend_q;
      divisor_d   = divisor_q;
      start_d     = start_q;
      annul_d     = 1'b0;
      rem_d       = rem_q;
      drain_cnt_d = drain_cnt;
      cache_v_d   = cache_v;
      cache_a_d   = cache_a;
      cache_b_d   = cache_b;
      cache_s_d   = cache_s;
      cache_q_d   = cache_q;
      cache_r_d   = cache_r;

      case (state)
         S_IDLE: begin
            if (req_i && !flush_i) begin
               rem_d       = op_rem;
               drain_cnt_d = '0;
               if (is_fast) begin
                  state_d  = S_FAST;
                  valid_d  = 1'b1;
                  result_d = op_rem ? fast_r : fast_q;
               end else begin
                  state_d    = S_WAIT;
                  signed_d   = op_signed;
                  dividend_d = rs1_i;
                  divisor_d  = rs2_i;
                  start_d    = 1'b1;
               end
            end
         end

         S_FAST: begin
            state_d = S_IDLE;
         end

         S_WAIT: begin
            // flush has priority: a result arriving with it is dropped and the
            // cache keeps its previous entry
            if (flush_i) begin
               state_d     = S_DRAIN;
               start_d     = 1'b0;
               annul_d     = 1'b1;
               drain_cnt_d = '0;
            end else if (div_ready_i) begin
               state_d     = S_DRAIN;
               start_d     = 1'b0;
               valid_d     = 1'b1;
               result_d    = rem_q ? div_result_i[63:32] : div_result_i[31:0];
               drain_cnt_d = '0;
               cache_v_d   = 1'b1;
               cache_a_d   = dividend_q;
               cache_b_d   = divisor_q;
               cache_s_d   = signed_q;
               cache_q_d   = div_result_i[31:0];
               cache_r_d   = div_result_i[63:32];
            end
         end

         S_DRAIN: begin
            // counter saturates at DRAIN_LAST; leaving also needs the divider
            // to have dropped ready so the next start sees it free
            if (drain_cnt == DRAIN_LAST) begin
               if (!div_ready_i) begin
                  state_d = S_IDLE;
               end
            end else begin
               drain_cnt_d = drain_cnt + 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // a flush in the cycle the fast result is presented kills that result
   assign valid_o        = valid_q & ~((state == S_FAST) & flush_i);
   assign busy_o         = busy;
   assign result_o       = result_q;
   assign div_signed_o   = signed_q;
   assign div_dividend_o = dividend_q;
   assign div_divisor_o  = divisor_q;
   assign div_start_o    = start_q;
   assign div_annul_o    = annul_q;
   assign dbg_state      = state;

endmodule

// File: tb/tb_div_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_div_ctrl
//   Self-checking bench for div_ctrl with a behavioural divider, a RISC-V
//   division reference model, a scoreboard queue and a decoupled monitor.
// -----------------------------------------------------------------------------
module tb_div_ctrl;

   localparam int DRAIN = 2;

   // ---------------- clock / reset ----------------
   logic        ck_i = 1'b0;
   logic        rs_n_i;
   logic        req_i;
   logic [1:0]  op_i;
   logic [31:0] rs1_i;
   logic [31:0] rs2_i;
   logic        flush_i;
   logic        busy_o;
   logic        valid_o;
   logic [31:0] result_o;
   logic        div_signed_o;
   logic [31:0] div_dividend_o;
   logic [31:0] div_divisor_o;
   logic        div_start_o;
   logic        div_annul_o;
   logic        div_ready_i;
   logic [63:0] div_result_i;
   logic [1:0]  dbg_state;

   always #5 ck_i = ~ck_i;

   div_ctrl #(.REUSE_EN(1'b1), .DRAIN_CYCLES(DRAIN)) dut (
      .ck_i(ck_i), .rs_n_i(rs_n_i), .req_i(req_i), .op_i(op_i),
      .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i),
      .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o),
      .div_signed_o(div_signed_o), .div_dividend_o(div_dividend_o),
      .div_divisor_o(div_divisor_o), .div_start_o(div_start_o),
      .div_annul_o(div_annul_o), .div_ready_i(div_ready_i),
      .div_result_i(div_result_i), .dbg_state(dbg_state)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always @(posedge ck_i) cyc = cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model (RISC-V division rules) ----------------
   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic        sg;
      logic [31:0] q, r;
      sg = ~op[0];
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else if (sg) begin
         q = 32'($signed(a) / $signed(b));
         r = 32'($signed(a) % $signed(b));
      end else begin
         q = a / b;
         r = a % b;
      end
      return op[1] ? r : q;
   endfunction

   // bench view of the reuse cache: last operands that went to the divider
   bit          c_v = 1'b0;
   logic [31:0] c_a, c_b;
   bit          c_s;

   // ---------------- behavioural divider ----------------
   int lat_force = 0;
   int dv_cnt, dv_lat, dv_hold;

   always @(posedge ck_i or negedge rs_n_i) begin
      if (!rs_n_i) begin
         div_ready_i  <= 1'b0;
         div_result_i <= '0;
         dv_cnt       <= 0;
         dv_lat       <= 0;
         dv_hold      <= 0;
      end else if (div_annul_o) begin
         div_ready_i <= 1'b0;
         dv_cnt      <= 0;
      end else if (div_start_o && !div_ready_i) begin
         if (dv_cnt == 0) begin
            dv_lat <= (lat_force != 0) ? lat_force : int'($urandom_range(2, 10));
            dv_cnt <= 1;
         end else if (dv_cnt >= dv_lat) begin
            div_ready_i  <= 1'b1;
            div_result_i <= {ref_div({1'b1, ~div_signed_o}, div_dividend_o, div_divisor_o),
                             ref_div({1'b0, ~div_signed_o}, div_dividend_o, div_divisor_o)};
            dv_hold      <= int'($urandom_range(0, 3));
         end else begin
            dv_cnt <= dv_cnt + 1;
         end
      end else if (!div_start_o && div_ready_i) begin
         if (dv_hold == 0) begin
            div_ready_i <= 1'b0;
            dv_cnt      <= 0;
         end else begin
            dv_hold <= dv_hold - 1;
         end
      end else if (!div_start_o) begin
         dv_cnt <= 0;
      end
   end

   // ---------------- scoreboard + monitor ----------------
   logic [31:0] exp_q[$];
   bit          fast_q[$];
   int          cyc_q[$];
   int          snap_q[$];

   int   start_cnt = 0;
   int   valid_cnt = 0;
   int   annul_cnt = 0;
   logic start_prev = 1'b0;

   always @(negedge ck_i) begin
      if (div_start_o && !start_prev) start_cnt++;
      start_prev = div_start_o;
      if (div_annul_o) annul_cnt++;
      if (rs_n_i && valid_o) begin
         valid_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got result %h with no expected entry", result_o);
         end else begin
            logic [31:0] e;
            bit          f;
            int          c, s;
            e = exp_q.pop_front();
            f = fast_q.pop_front();
            c = cyc_q.pop_front();
            s = snap_q.pop_front();
            check("result", {32'd0, result_o}, {32'd0, e});
            if (f) begin
               check("fast_latency", 64'(cyc - c), 64'd1);
               check("fast_no_start", 64'(start_cnt - s), 64'd0);
            end else begin
               check("div_one_start", 64'(start_cnt - s), 64'd1);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_idle();
      int n = 0;
      @(posedge ck_i); #1;
      while (busy_o && n < 200) begin
         @(posedge ck_i); #1;
         n++;
      end
      if (busy_o) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: got busy %b expected 0", busy_o);
      end
   endtask

   // issues one operation, pushes the expectation, drops req on valid
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res);
      bit sg, fast;
      int n;
      wait_idle();
      sg   = ~op[0];
      fast = (b == 32'd0) || (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
             (c_v && a == c_a && b == c_b && sg == c_s);
      if (!fast) begin
         c_v = 1'b1;
         c_a = a;
         c_b = b;
         c_s = sg;
      end
      exp_q.push_back(exp_res);
      fast_q.push_back(fast);
      cyc_q.push_back(cyc);
      snap_q.push_back(start_cnt);
      req_i = 1'b1;
      op_i  = op;
      rs1_i = a;
      rs2_i = b;
      n = 0;
      do begin
         @(posedge ck_i); #1;
         n++;
      end while (!valid_o && n < 300);
      req_i = 1'b0;
      if (!valid_o) begin
         checks++;
         errors++;
         $display("FAIL valid_timeout: got no valid for op %0d %h/%h expected one", op, a, b);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n, vsnap, asnap;
      logic [31:0] a, b, pa, pb;
      logic [1:0]  op;

      rs_n_i  = 1'b0;
      req_i   = 1'b0;
      flush_i = 1'b0;
      op_i    = 2'd0;
      rs1_i   = 32'd0;
      rs2_i   = 32'd0;
      repeat (3) @(posedge ck_i);
      #1;
      check("reset_ctl", {59'd0, busy_o, valid_o, div_start_o, div_annul_o, div_signed_o}, 64'd0);
      check("reset_data", {result_o, div_dividend_o | div_divisor_o}, 64'd0);
      rs_n_i = 1'b1;

      // quotient via divider, then remainder served from the cache
      run_op(2'b00, 32'd100, 32'd7, 32'h0000_000E);
      run_op(2'b10, 32'd100, 32'd7, 32'h0000_0002);
      // signed negative dividend; REMU misses because signedness differs
      run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001);
      // divide by zero
      run_op(2'b01, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
      run_op(2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678);
      // signed overflow
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

      // request with flush in idle is ignored
      wait_idle();
      vsnap   = valid_cnt;
      req_i   = 1'b1;
      flush_i = 1'b1;
      op_i    = 2'b01;
      rs1_i   = 32'd5;
      rs2_i   = 32'd0;
      @(posedge ck_i); #1;
      req_i   = 1'b0;
      flush_i = 1'b0;
      check("idle_flush_busy", {63'd0, busy_o}, 64'd0);
      @(posedge ck_i); #1;
      check("idle_flush_no_valid", 64'(valid_cnt - vsnap), 64'd0);

      // flush while the fast result is presented suppresses it
      wait_idle();
      vsnap = valid_cnt;
      req_i = 1'b1;
      op_i  = 2'b01;
      rs1_i = 32'd77;
      rs2_i = 32'd0;
      @(posedge ck_i); #1;
      flush_i = 1'b1;
      req_i   = 1'b0;
      @(posedge ck_i); #1;
      flush_i = 1'b0;
      check("fast_flush_no_valid", 64'(valid_cnt - vsnap), 64'd0);
      check("fast_flush_idle", {63'd0, busy_o}, 64'd0);

      // flush ten cycles into a divider wait
      wait_idle();
      lat_force = 40;
      vsnap     = valid_cnt;
      asnap     = annul_cnt;
      req_i     = 1'b1;
      op_i      = 2'b00;
      rs1_i     = 32'd1000;
      rs2_i     = 32'd7;
      repeat (10) @(posedge ck_i);
      #1;
      check("wait_busy_start", {62'd0, busy_o, div_start_o}, 64'd3);
      flush_i = 1'b1;
      req_i   = 1'b0;
      @(posedge ck_i); #1;
      flush_i = 1'b0;
      n = 0;
      while (busy_o && n < 50) begin
         n++;
         @(posedge ck_i); #1;
      end
      check("drain_min_cycles", {63'd0, (n >= DRAIN && n < 50)}, 64'd1);
      repeat (3) @(posedge ck_i);
      check("annul_one_pulse", 64'(annul_cnt - asnap), 64'd1);
      check("flush_no_valid", 64'(valid_cnt - vsnap), 64'd0);
      lat_force = 0;
      run_op(2'b00, 32'd9, 32'd3, 32'h0000_0003);

      // reset in the middle of a divider wait; cache is cleared by it
      run_op(2'b01, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF);
      wait_idle();
      lat_force = 40;
      req_i     = 1'b1;
      op_i      = 2'b00;
      rs1_i     = 32'd50;
      rs2_i     = 32'd5;
      repeat (5) @(posedge ck_i);
      #1;
      rs_n_i = 1'b0;
      req_i  = 1'b0;
      #1;
      check("midreset_ctl", {59'd0, busy_o, valid_o, div_start_o, div_annul_o, div_signed_o}, 64'd0);
      check("midreset_data", {result_o, div_dividend_o | div_divisor_o}, 64'd0);
      @(posedge ck_i); #1;
      rs_n_i    = 1'b1;
      c_v       = 1'b0;
      lat_force = 0;
      run_op(2'b01, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF);

      // randomized mix with frequent operand repeats to exercise the cache
      pa = 32'd1;
      pb = 32'd1;
      for (int i = 0; i < 40; i++) begin
         int kind;
         op   = 2'($urandom_range(0, 3));
         kind = int'($urandom_range(0, 9));
         if (kind == 0) begin
            a = $urandom;
            b = 32'd0;
         end else if (kind == 1) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end else if (kind <= 4) begin
            a = pa;
            b = pb;
         end else begin
            a = $urandom;
            b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 20)) : $urandom;
            if ($urandom_range(0, 2) == 0) b = -b;
         end
         pa = a;
         pb = b;
         run_op(op, a, b, ref_div(op, a, b));
      end

      wait_idle();
      repeat (5) @(posedge ck_i);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no completion expected finish");
      $fatal(1, "timeout");
   end

endmodule
